// File: rtl/rams_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port RAM.
// Reads return through a two-stage pipeline to the port of the requester that issued them.
module rams_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          last_grant;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          s1_valid;
  logic          s1_tag;
  logic [DW-1:0] s1_data;

  // last_grant = 1 means requester 1 won most recently, so requester 0 wins the next tie
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = !last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept    = req0_ready | req1_ready;
  assign sel_we    = req1_ready ? req1_we    : req0_we;
  assign sel_addr  = req1_ready ? req1_addr  : req0_addr;
  assign sel_wdata = req1_ready ? req1_wdata : req0_wdata;

  // RAM array and its registered read port carry no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (accept && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
    s1_data <= mem[sel_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      s1_valid   <= 1'b0;
      s1_tag     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      if (accept) begin
        last_grant <= req1_ready;
      end
      s1_valid   <= accept && !sel_we;
      s1_tag     <= req1_ready;
      rsp0_valid <= s1_valid && !s1_tag;
      rsp1_valid <= s1_valid && s1_tag;
      // each response register only moves when its own requester's read completes
      if (s1_valid && !s1_tag) begin
        rsp0_data <= s1_data;
      end
      if (s1_valid && s1_tag) begin
        rsp1_data <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_rams_arbiter.sv
// Directed bench for rams_arbiter: a per-cycle vector table followed by hand-written
// sequences for reset during an in-flight read and post-reset arbitration and latency.
module tb_rams_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NV = 31;

  typedef struct {
    logic          rst;
    logic          v0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e_rdy0;
    logic          e_rdy1;
    logic          e_rv0;
    logic [DW-1:0] e_rd0;
    logic          e_rv1;
    logic [DW-1:0] e_rd1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [NV];

  rams_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r,
    input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic er0, input logic er1,
    input logic ev0, input logic [DW-1:0] ed0,
    input logic ev1, input logic [DW-1:0] ed1);
    vec_t v;
    v.rst = r;
    v.v0 = v0; v.we0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = w1; v.a1 = a1; v.d1 = d1;
    v.e_rdy0 = er0; v.e_rdy1 = er1;
    v.e_rv0 = ev0; v.e_rd0 = ed0;
    v.e_rv1 = ev1; v.e_rd1 = ed1;
    return v;
  endfunction

  // Drives one cycle's worth of inputs; called just after a negedge
  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    req0_valid = v.v0;
    req0_we    = v.we0;
    req0_addr  = v.a0;
    req0_wdata = v.d0;
    req1_valid = v.v1;
    req1_we    = v.we1;
    req1_addr  = v.a1;
    req1_wdata = v.d1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    return mk(0, 0,0,'0,'0, 0,0,'0,'0, 0,0, 0,'0, 0,'0);
  endfunction

  initial begin
    vec_t v;
    int   lat;
    logic seen0;

    // reset and the write-then-read check, with both requesters held off by reset
    vecs[0]  = mk(1, 1,0,10'h005,16'h0000, 1,0,10'h007,16'h0000, 0,0, 0,16'h0000, 0,16'h0000);
    vecs[1]  = mk(0, 1,1,10'h005,16'hA5A5, 0,0,10'h000,16'h0000, 1,0, 0,16'h0000, 0,16'h0000);
    vecs[2]  = mk(0, 1,0,10'h005,16'h0000, 0,0,10'h000,16'h0000, 1,0, 0,16'h0000, 0,16'h0000);
    vecs[3]  = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'h0000, 0,16'h0000);
    vecs[4]  = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 1,16'hA5A5, 0,16'h0000);
    vecs[5]  = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'hA5A5, 0,16'h0000);
    // requester 1 preloads around the address wrap, then streams four reads
    vecs[6]  = mk(0, 0,0,10'h000,16'h0000, 1,1,10'h3FF,16'h1111, 0,1, 0,16'hA5A5, 0,16'h0000);
    vecs[7]  = mk(0, 0,0,10'h000,16'h0000, 1,1,10'h000,16'h2222, 0,1, 0,16'hA5A5, 0,16'h0000);
    vecs[8]  = mk(0, 0,0,10'h000,16'h0000, 1,1,10'h001,16'h3333, 0,1, 0,16'hA5A5, 0,16'h0000);
    vecs[9]  = mk(0, 0,0,10'h000,16'h0000, 1,1,10'h002,16'h4444, 0,1, 0,16'hA5A5, 0,16'h0000);
    vecs[10] = mk(0, 0,0,10'h000,16'h0000, 1,0,10'h3FF,16'h0000, 0,1, 0,16'hA5A5, 0,16'h0000);
    vecs[11] = mk(0, 0,0,10'h000,16'h0000, 1,0,10'h000,16'h0000, 0,1, 0,16'hA5A5, 0,16'h0000);
    vecs[12] = mk(0, 0,0,10'h000,16'h0000, 1,0,10'h001,16'h0000, 0,1, 0,16'hA5A5, 1,16'h1111);
    vecs[13] = mk(0, 0,0,10'h000,16'h0000, 1,0,10'h002,16'h0000, 0,1, 0,16'hA5A5, 1,16'h2222);
    vecs[14] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'hA5A5, 1,16'h3333);
    vecs[15] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'hA5A5, 1,16'h4444);
    vecs[16] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'hA5A5, 0,16'h4444);
    // continuous contention: grants alternate starting with requester 0
    vecs[17] = mk(0, 1,0,10'h005,16'h0000, 1,0,10'h3FF,16'h0000, 1,0, 0,16'hA5A5, 0,16'h4444);
    vecs[18] = mk(0, 1,0,10'h000,16'h0000, 1,0,10'h3FF,16'h0000, 0,1, 0,16'hA5A5, 0,16'h4444);
    vecs[19] = mk(0, 1,0,10'h000,16'h0000, 1,0,10'h002,16'h0000, 1,0, 1,16'hA5A5, 0,16'h4444);
    vecs[20] = mk(0, 1,0,10'h001,16'h0000, 1,0,10'h002,16'h0000, 0,1, 0,16'hA5A5, 1,16'h1111);
    vecs[21] = mk(0, 1,0,10'h001,16'h0000, 1,0,10'h005,16'h0000, 1,0, 1,16'h2222, 0,16'h1111);
    vecs[22] = mk(0, 1,0,10'h001,16'h0000, 1,0,10'h005,16'h0000, 0,1, 0,16'h2222, 1,16'h4444);
    vecs[23] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 1,16'h3333, 0,16'h4444);
    vecs[24] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'h3333, 1,16'hA5A5);
    vecs[25] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'h3333, 0,16'hA5A5);
    // write by requester 0 beats a read by requester 1, which then sees the new data
    vecs[26] = mk(0, 1,1,10'h010,16'hBEEF, 1,0,10'h010,16'h0000, 1,0, 0,16'h3333, 0,16'hA5A5);
    vecs[27] = mk(0, 0,0,10'h000,16'h0000, 1,0,10'h010,16'h0000, 0,1, 0,16'h3333, 0,16'hA5A5);
    vecs[28] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'h3333, 0,16'hA5A5);
    vecs[29] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'h3333, 1,16'hBEEF);
    vecs[30] = mk(0, 0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,16'h3333, 0,16'hBEEF);

    v = idle();
    v.rst = 1'b1;
    applyStimulus(v);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req0_ready", i), {15'd0, req0_ready}, {15'd0, vecs[i].e_rdy0});
      checkOutput($sformatf("v%0d req1_ready", i), {15'd0, req1_ready}, {15'd0, vecs[i].e_rdy1});
      checkOutput($sformatf("v%0d rsp0_valid", i), {15'd0, rsp0_valid}, {15'd0, vecs[i].e_rv0});
      checkOutput($sformatf("v%0d rsp0_data", i), rsp0_data, vecs[i].e_rd0);
      checkOutput($sformatf("v%0d rsp1_valid", i), {15'd0, rsp1_valid}, {15'd0, vecs[i].e_rv1});
      checkOutput($sformatf("v%0d rsp1_data", i), rsp1_data, vecs[i].e_rd1);
    end

    // read in flight when reset arrives must never produce a response
    @(negedge clk);
    v = mk(0, 1,0,10'h005,16'h0000, 0,0,10'h000,16'h0000, 0,0, 0,'0, 0,'0);
    applyStimulus(v);
    #1;
    checkOutput("inflight accept", {15'd0, req0_ready}, 16'd1);
    @(negedge clk);
    v.rst = 1'b1;
    applyStimulus(v);
    #1;
    checkOutput("ready forced in reset", {15'd0, req0_ready}, 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus(idle());
      #1;
      checkOutput($sformatf("discard rsp0_valid c%0d", k), {15'd0, rsp0_valid}, 16'd0);
      checkOutput($sformatf("discard rsp0_data c%0d", k), rsp0_data, 16'h0000);
    end
    checkOutput("rsp1_data cleared", rsp1_data, 16'h0000);

    // pointer restarts favouring requester 0; RAM keeps its contents across reset
    @(negedge clk);
    applyStimulus(mk(0, 1,0,10'h010,16'h0000, 1,0,10'h010,16'h0000, 0,0, 0,'0, 0,'0));
    #1;
    checkOutput("post-reset req0 wins", {15'd0, req0_ready}, 16'd1);
    checkOutput("post-reset req1 waits", {15'd0, req1_ready}, 16'd0);
    @(negedge clk);
    applyStimulus(mk(0, 0,0,10'h000,16'h0000, 1,0,10'h010,16'h0000, 0,0, 0,'0, 0,'0));
    #1;
    checkOutput("post-reset req1 granted", {15'd0, req1_ready}, 16'd1);
    lat   = 0;
    seen0 = 1'b0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      applyStimulus(idle());
      #1;
      if (k == 1) seen0 = rsp0_valid;
      if (rsp1_valid) lat = k;
    end
    checkOutput("req1 read latency", 16'(lat), 16'd2);
    checkOutput("req1 data kept over reset", rsp1_data, 16'hBEEF);
    checkOutput("req0 response order", {15'd0, seen0}, 16'd1);
    checkOutput("req0 data kept over reset", rsp0_data, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rams_arbiter.md
RAMS_ARBITER -- requirements
Module: rams_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning RAM address width (depth 2**AW words).
REQ-002 The block SHALL have parameter DW, default 16, meaning RAM data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 has an access pending.
REQ-006 req0_ready  output  1  requester 0 access accepted this cycle.
REQ-007 req0_we  input  1  1 = write, 0 = read.
REQ-008 req0_addr  input  AW  requester 0 word address.
REQ-009 req0_wdata  input  DW  requester 0 write data.
REQ-010 req1_valid, req1_ready, req1_we, req1_addr, req1_wdata SHALL mirror REQ-005..009 for requester 1.
REQ-011 rsp0_valid  output  1  one-cycle pulse: rsp0_data holds requester 0 read result.
REQ-012 rsp0_data  output  DW  requester 0 read data.
REQ-013 rsp1_valid, rsp1_data SHALL mirror REQ-011..012 for requester 1.

Function
REQ-014 The block SHALL contain one inferred single-port 2**AW x DW RAM, accessed at most once per cycle.
REQ-015 An access SHALL be accepted in a cycle where reqN_valid && reqN_ready; reqN_ready SHALL be combinational from valids and arbiter state, and 0 when reqN_valid is 0.
REQ-016 At most one of req0_ready/req1_ready SHALL be 1 in any cycle.
REQ-017 Single requester valid: that requester SHALL be granted the same cycle.
REQ-018 Both valid: the requester not granted most recently SHALL win (round-robin); last-grant pointer SHALL update only on an accepted access.
REQ-019 Accepted write: RAM[addr] <= wdata at that posedge; no response generated.
REQ-020 Accepted read: stage 1 SHALL register RAM[addr] plus a requester tag and valid; stage 2 SHALL register stage-1 data into the output register of the tagged requester.
REQ-021 Read latency SHALL be exactly 2 cycles: read accepted at edge N -> rspX_valid = 1 for exactly the cycle after edge N+2.
REQ-022 Reads SHALL be fully pipelined: back-to-back accepted reads yield back-to-back responses in acceptance order.
REQ-023 rspX_data SHALL hold its last value when rspX_valid = 0; the other requester's response SHALL not alter it.
REQ-024 Read accepted the cycle after a write to the same address SHALL return the new data (write-first ordering through RAM).
REQ-025 Responses have no backpressure; requesters SHALL always sink rspX_valid.
REQ-026 Address wrap: addresses are modulo 2**AW; no out-of-range condition exists.

Reset
REQ-027 While rst = 1 at a posedge: req0_ready/req1_ready SHALL be 0 (combinationally forced), pipeline valids cleared, rsp0_valid = rsp1_valid = 0, rsp0_data = rsp1_data = 0, last-grant pointer = requester 1 (so requester 0 wins first contention).
REQ-028 Reads in flight when rst asserts SHALL be discarded; no rspX_valid pulse SHALL appear for them after rst deasserts.
REQ-029 RAM contents SHALL not be reset; no write SHALL occur while rst = 1.
REQ-030 First access SHALL be acceptable in the first cycle with rst = 0.

Verification
REQ-031 After reset, req0 write addr 0x005 data 0xA5A5, next cycle req0 read 0x005 -> rsp0_valid 2 cycles after read accepted, rsp0_data = 0xA5A5, rsp1_valid stays 0.
REQ-032 Both valid continuously for 6 cycles (reads) after reset -> grants 0,1,0,1,0,1; each response on the matching rspX port 2 cycles after its grant.
REQ-033 Only req1 valid for 4 cycles, reads addr 0x3FF,0x000,0x001,0x002 pre-loaded 0x1111,0x2222,0x3333,0x4444 -> req1_ready = 1 each cycle, rsp1_data 0x1111..0x4444 on 4 consecutive cycles.
REQ-034 req0 read accepted, rst asserted next cycle for 1 cycle -> no rsp0_valid at any later cycle; rsp0_data = 0.
REQ-035 req0 writes 0x0010 <- 0xBEEF while req1 reads 0x0010 concurrently (contention, req0 wins) -> req1 granted next cycle, rsp1_data = 0xBEEF.
